game_turn_controller: RTL
=========================

GAME_TURN_CONTROLLER -- requirements
Module: game_turn_controller

Interface
REQ-001 Parameter NUM_PLAYERS, default 2, number of players taking turns, legal range 2..4.
REQ-002 Parameter TURN_CYCLES, default 50_000_000, clock cycles allowed per turn before timeout, minimum 2.
REQ-003 Parameter BOARD_CELLS, default 9, number of moves after which a game without a win is a tie.
REQ-004 Port clk  input  1  the only clock; all state updates on the rising edge.
REQ-005 Port rst  input  1  synchronous, active-high reset.
REQ-006 Port start  input  1  level; begins a game from IDLE or a new game from GAME_OVER.
REQ-007 Ports ready, valid, win, tie  input  1 each  player move submitted, move legal, win detected, tie detected.
REQ-008 Ports timer_run, validate_play, play_random, validate_win, change_turn, print_sprite, print_win  output  1 each  Moore strobes decoded from the registered state.
REQ-009 Port player  output  $clog2(NUM_PLAYERS)  index of the current player.
REQ-010 Port time_left  output  $clog2(TURN_CYCLES)  remaining turn cycles.
REQ-011 Port move_count  output  $clog2(BOARD_CELLS+1)  accepted moves in the current game.
REQ-012 Ports winner [player width], tie_flag [1], scores [NUM_PLAYERS*8]  outputs  result of the last game and per-player win counts.

Function
REQ-013 The states SHALL be IDLE, TURN, RANDOM, CHECK_PLAY, CHECK_WIN, NEXT, GAME_OVER; outputs change one cycle after the state transition.
REQ-014 IDLE: start -> TURN; player=first_player=0, move_count=0, timer loaded with TURN_CYCLES-1.
REQ-015 TURN: timer_run=1, timer decrements each cycle; ready -> CHECK_PLAY; else timer==0 -> RANDOM; ready wins over a simultaneous timeout.
REQ-016 RANDOM: play_random=1; valid -> CHECK_WIN; else stay in RANDOM (the generator retries).
REQ-017 CHECK_PLAY: validate_play=1; valid -> CHECK_WIN; else -> TURN with the timer not reloaded.
REQ-018 On each transition into CHECK_WIN, move_count SHALL increment by 1.
REQ-019 CHECK_WIN: validate_win=1; win -> GAME_OVER with winner=player and tie_flag=0; else tie or move_count==BOARD_CELLS -> GAME_OVER with tie_flag=1; otherwise -> NEXT; win takes priority over tie.
REQ-020 NEXT: change_turn=1, print_sprite=1; player increments and wraps from NUM_PLAYERS-1 to 0; timer reloaded; -> TURN.
REQ-021 On a win, scores[winner] SHALL increment and saturate at 255.
REQ-022 GAME_OVER: print_win=1; start -> TURN with move_count=0, first_player incremented with wrap, player=new first_player, timer reloaded; scores retained.
REQ-023 Unused state encodings SHALL go to IDLE on the next cycle.

Reset
REQ-024 rst=1 at a clock edge SHALL force IDLE, clear player, first_player, move_count, time_left, winner, tie_flag and all scores, and deassert all strobes, from any state including mid-turn.

Configuration
REQ-025 With TURN_TIMER_EN defined, the turn timer SHALL behave as in REQ-015.
REQ-026 With TURN_TIMER_EN undefined, TURN SHALL wait on ready indefinitely, RANDOM SHALL be unreachable, play_random SHALL be 0, time_left SHALL be 0 and timer_run SHALL be 0.

Structure
REQ-027 Package game_ctrl_pkg SHALL hold the state enum, the 8-bit score width constant and the maximum player count.
REQ-028 A sub-module turn_timer SHALL provide the loadable down-counter with load, enable and zero flag.

Verification
REQ-029 Reset and start: NUM_PLAYERS=3, TURN_CYCLES=5, BOARD_CELLS=9; start=1 after reset -> TURN, player=0, time_left=4.
REQ-030 Timeout: no ready in TURN -> RANDOM after 5 TURN cycles, play_random=1; valid=1 -> CHECK_WIN, move_count=1.
REQ-031 Invalid move: ready with valid=0 at time_left=2 -> back to TURN with time_left still counting from 2, not reloaded.
REQ-032 Rotation: three valid non-winning moves -> player sequence 0,1,2,0; change_turn pulses once per move.
REQ-033 Win and restart: win=1 in CHECK_WIN with player=1 -> winner=1, scores[1]=1, print_win=1; start -> TURN with player=1.
REQ-034 Forced tie and reset: ninth valid move with win=0, tie=0 -> tie_flag=1; rst=1 mid-TURN -> IDLE with all counters cleared.

Source files
------------

// File: rtl/game_ctrl_pkg.sv
// Shared state encoding and sizing constants for the game turn controller.
package game_ctrl_pkg;

   localparam int SCORE_W     = 8;
   localparam int MAX_PLAYERS = 4;

   localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_TURN       = 3'd1,
      S_RANDOM     = 3'd2,
      S_CHECK_PLAY = 3'd3,
      S_CHECK_WIN  = 3'd4,
      S_NEXT       = 3'd5,
      S_GAME_OVER  = 3'd6
   } state_e;

endpackage

// File: rtl/turn_timer.sv
// Loadable down-counter holding the remaining cycles of the current turn.
// Load wins over enable; the count holds once it reaches zero.
module turn_timer #(
   parameter int               WIDTH      = 26,
   parameter logic [WIDTH-1:0] LOAD_VALUE = '1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic             en_i,
   output logic [WIDTH-1:0] count_o,
   output logic             zero_o
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = LOAD_VALUE;
      end else if (en_i && (count_q != '0)) begin
         count_d = count_q - WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
   assign zero_o  = (count_q == '0);

endmodule

// File: rtl/game_turn_controller.sv
// Turn sequencer for a multi-player board game: move validation, win/tie, scores.
// Define TURN_TIMER_EN to enable the per-turn timeout and random-move fallback.
module game_turn_controller
   import game_ctrl_pkg::*;
#(
   parameter int NUM_PLAYERS = 2,
   parameter int TURN_CYCLES = 50_000_000,
   parameter int BOARD_CELLS = 9
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               start,
   input  logic                               ready,
   input  logic                               valid,
   input  logic                               win,
   input  logic                               tie,
   output logic                               timer_run,
   output logic                               validate_play,
   output logic                               play_random,
   output logic                               validate_win,
   output logic                               change_turn,
   output logic                               print_sprite,
   output logic                               print_win,
   output logic [$clog2(NUM_PLAYERS)-1:0]     player,
   output logic [$clog2(TURN_CYCLES)-1:0]     time_left,
   output logic [$clog2(BOARD_CELLS+1)-1:0]   move_count,
   output logic [$clog2(NUM_PLAYERS)-1:0]     winner,
   output logic                               tie_flag,
   output logic [NUM_PLAYERS*SCORE_W-1:0]     scores
);

   localparam int PW = $clog2(NUM_PLAYERS);
   localparam int TW = $clog2(TURN_CYCLES);
   localparam int MW = $clog2(BOARD_CELLS+1);

   localparam logic [2:0] ST_IDLE       = S_IDLE;
   localparam logic [2:0] ST_TURN       = S_TURN;
   localparam logic [2:0] ST_RANDOM     = S_RANDOM;
   localparam logic [2:0] ST_CHECK_PLAY = S_CHECK_PLAY;
   localparam logic [2:0] ST_CHECK_WIN  = S_CHECK_WIN;
   localparam logic [2:0] ST_NEXT       = S_NEXT;
   localparam logic [2:0] ST_GAME_OVER  = S_GAME_OVER;

   logic [2:0]    state_q,  state_d;
   logic [PW-1:0] player_q, player_d;
   logic [PW-1:0] first_q,  first_d;
   logic [MW-1:0] moves_q,  moves_d;
   logic [PW-1:0] winner_q, winner_d;
   logic          tie_q,    tie_d;
   logic          timer_load;
   logic          timer_zero;
   logic          score_inc;

   always_comb begin
      state_d    = state_q;
      player_d   = player_q;
      first_d    = first_q;
      moves_d    = moves_q;
      winner_d   = winner_q;
      tie_d      = tie_q;
      timer_load = 1'b0;
      score_inc  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d    = ST_TURN;
               player_d   = '0;
               first_d    = '0;
               moves_d    = '0;
               timer_load = 1'b1;
            end
         end
         ST_TURN: begin
            if (ready) begin
               state_d = ST_CHECK_PLAY;
            end else if (timer_zero) begin
               state_d = ST_RANDOM;
            end
         end
         ST_RANDOM: begin
            if (valid) begin
               state_d = ST_CHECK_WIN;
               moves_d = moves_q + MW'(1);
            end
         end
         ST_CHECK_PLAY: begin
            if (valid) begin
               state_d = ST_CHECK_WIN;
               moves_d = moves_q + MW'(1);
            end else begin
               state_d = ST_TURN;
            end
         end
         ST_CHECK_WIN: begin
            // moves_q already counts the move under test here
            if (win) begin
               state_d   = ST_GAME_OVER;
               winner_d  = player_q;
               tie_d     = 1'b0;
               score_inc = 1'b1;
            end else if (tie || (moves_q == MW'(BOARD_CELLS))) begin
               state_d = ST_GAME_OVER;
               tie_d   = 1'b1;
            end else begin
               state_d = ST_NEXT;
            end
         end
         ST_NEXT: begin
            state_d    = ST_TURN;
            player_d   = (player_q == PW'(NUM_PLAYERS-1)) ? '0 : player_q + PW'(1);
            timer_load = 1'b1;
         end
         ST_GAME_OVER: begin
            if (start) begin
               state_d    = ST_TURN;
               first_d    = (first_q == PW'(NUM_PLAYERS-1)) ? '0 : first_q + PW'(1);
               player_d   = first_d;
               moves_d    = '0;
               timer_load = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         player_q <= '0;
         first_q  <= '0;
         moves_q  <= '0;
         winner_q <= '0;
         tie_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         player_q <= player_d;
         first_q  <= first_d;
         moves_q  <= moves_d;
         winner_q <= winner_d;
         tie_q    <= tie_d;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_PLAYERS; gi++) begin : g_score
         logic [SCORE_W-1:0] score_q;
         always_ff @(posedge clk) begin
            if (rst) begin
               score_q <= '0;
            end else if (score_inc && (player_q == PW'(gi)) && (score_q != SCORE_MAX)) begin
               score_q <= score_q + SCORE_W'(1);
            end
         end
         assign scores[gi*SCORE_W +: SCORE_W] = score_q;
      end
   endgenerate

`ifdef TURN_TIMER_EN
   // The timer pauses while a submitted move is validated, so a rejected move
   // resumes the turn with the time it had when ready was raised.
   turn_timer #(
      .WIDTH      (TW),
      .LOAD_VALUE (TW'(TURN_CYCLES-1))
   ) u_turn_timer (
      .clk     (clk),
      .rst     (rst),
      .load_i  (timer_load),
      .en_i    ((state_q == ST_TURN) && !ready),
      .count_o (time_left),
      .zero_o  (timer_zero)
   );
   assign timer_run   = (state_q == ST_TURN);
   assign play_random = (state_q == ST_RANDOM);
`else
   logic unused_timer_load;
   assign unused_timer_load = timer_load;
   assign timer_zero        = 1'b0;
   assign time_left         = '0;
   assign timer_run         = 1'b0;
   assign play_random       = 1'b0;
`endif

   assign validate_play = (state_q == ST_CHECK_PLAY);
   assign validate_win  = (state_q == ST_CHECK_WIN);
   assign change_turn   = (state_q == ST_NEXT);
   assign print_sprite  = (state_q == ST_NEXT);
   assign print_win     = (state_q == ST_GAME_OVER);
   assign player        = player_q;
   assign move_count    = moves_q;
   assign winner        = winner_q;
   assign tie_flag      = tie_q;

endmodule
